// File: rtl/macc_pkg.sv
// Shared constants and helpers for the decimator MAC datapath and the interpolator output stage.
package macc_pkg;

  // Width of the generic signed value handled by the saturate helper.
  localparam int unsigned SatWidth = 64;

  typedef struct packed {
    logic                       clipped;
    logic signed [SatWidth-1:0] value;
  } sat_t;

  // Accumulator width: full product plus guard bits against growth over a dot product.
  function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned coeff_w,
                                            input int unsigned guard_b);
    return data_w + coeff_w + guard_b;
  endfunction

  // Largest value representable in a signed out_w-bit result.
  function automatic logic signed [SatWidth-1:0] out_max(input int unsigned out_w);
    return (64'sd1 <<< (out_w - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a signed out_w-bit result.
  function automatic logic signed [SatWidth-1:0] out_min(input int unsigned out_w);
    return -(64'sd1 <<< (out_w - 1));
  endfunction

  // Clip val into the signed out_w-bit range and flag whether clipping happened.
  function automatic sat_t saturate(input logic signed [SatWidth-1:0] val,
                                    input int unsigned out_w);
    sat_t res;
    res.clipped = 1'b0;
    res.value   = val;
    if (val > out_max(out_w)) begin
      res.clipped = 1'b1;
      res.value   = out_max(out_w);
    end else if (val < out_min(out_w)) begin
      res.clipped = 1'b1;
      res.value   = out_min(out_w);
    end
    return res;
  endfunction

endpackage

// File: rtl/macc_round_sat.sv
// Combinational round / shift / clip of the accumulator into one output sample.
// MACC_ROUND_EN selects round-half-up; otherwise the shift truncates toward -inf.
module macc_round_sat
  import macc_pkg::*;
#(
  parameter int unsigned AccWidth  = 36,
  parameter int unsigned ShiftBits = 15,
  parameter int unsigned OutWidth  = 16
) (
  input  logic signed [AccWidth-1:0] acc_i,
  output logic signed [OutWidth-1:0] result_o,
  output logic                       clipped_o
);

  // One extra MSB so the rounding addition can never wrap.
  logic signed [AccWidth:0] acc_ext;
  logic signed [AccWidth:0] rounded;
  logic signed [AccWidth:0] shifted;
  logic signed [SatWidth-1:0] shifted_ext;
  sat_t sat_res;
  logic unused_sat_hi;

`ifdef MACC_ROUND_EN
  localparam logic [AccWidth:0] RoundConst = {{AccWidth{1'b0}}, 1'b1} << (ShiftBits - 1);
`endif

  // Round, arithmetic shift, sign-extend to the helper width and clip.
  always_comb begin
    acc_ext = {acc_i[AccWidth-1], acc_i};
`ifdef MACC_ROUND_EN
    rounded = acc_ext + $signed(RoundConst);
`else
    rounded = acc_ext;
`endif
    shifted     = rounded >>> ShiftBits;
    shifted_ext = {{(SatWidth - AccWidth - 1){shifted[AccWidth]}}, shifted};
    sat_res     = saturate(shifted_ext, OutWidth);
  end

  assign result_o      = sat_res.value[OutWidth-1:0];
  assign clipped_o     = sat_res.clipped;
  // Bits above OutWidth are redundant after clipping.
  assign unused_sat_hi = ^sat_res.value[SatWidth-1:OutWidth];

endmodule

// File: rtl/macc_accumulator.sv
// Multiply-accumulate datapath of the L/M decimator: product stage P, accumulate stage A,
// registered round/saturate output stage O. Optional rounding via the MACC_ROUND_EN macro.
module macc_accumulator
  import macc_pkg::*;
#(
  parameter int unsigned DataWidth  = 16,
  parameter int unsigned CoeffWidth = 16,
  parameter int unsigned GuardBits  = 4,
  parameter int unsigned ShiftBits  = 15,
  parameter int unsigned OutWidth   = 16
) (
  input  logic                         Clk_i,
  input  logic                         Rst_i,
  input  logic signed [DataWidth-1:0]  Data_i,
  input  logic signed [CoeffWidth-1:0] Coeff_i,
  input  logic                         StartAcc_i,
  input  logic                         DataValid_i,
  output logic signed [OutWidth-1:0]   Result_o,
  output logic                         ResultValid_o,
  output logic                         Sat_o
);

  localparam int unsigned ProdWidth = DataWidth + CoeffWidth;
  localparam int unsigned AccWidth  = acc_width(DataWidth, CoeffWidth, GuardBits);

  logic signed [ProdWidth-1:0] prod_d, prod_q;
  logic signed [AccWidth-1:0]  prod_ext, acc_d, acc_q;
  logic                        start_p_q, done_a_q;
  logic signed [OutWidth-1:0]  rs_result, result_q;
  logic                        rs_clipped, sat_q, valid_q;

  // Next-state for product and accumulator; a start reloads instead of adding.
  always_comb begin
    prod_d   = ProdWidth'(Data_i) * ProdWidth'(Coeff_i);
    prod_ext = {{GuardBits{prod_q[ProdWidth-1]}}, prod_q};
    acc_d    = start_p_q ? prod_ext : acc_q + prod_ext;
  end

  macc_round_sat #(
    .AccWidth (AccWidth),
    .ShiftBits(ShiftBits),
    .OutWidth (OutWidth)
  ) u_round_sat (
    .acc_i    (acc_q),
    .result_o (rs_result),
    .clipped_o(rs_clipped)
  );

  // Pipeline registers; result and sat only update on doneA and otherwise hold.
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      prod_q    <= '0;
      start_p_q <= 1'b0;
      acc_q     <= '0;
      done_a_q  <= 1'b0;
      result_q  <= '0;
      sat_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      prod_q    <= prod_d;
      start_p_q <= StartAcc_i;
      acc_q     <= acc_d;
      done_a_q  <= DataValid_i;
      valid_q   <= done_a_q;
      if (done_a_q) begin
        result_q <= rs_result;
        sat_q    <= rs_clipped;
      end
    end
  end

  assign Result_o      = result_q;
  assign ResultValid_o = valid_q;
  assign Sat_o         = sat_q;

endmodule

// File: tb/tb_macc_accumulator.sv
// Self-checking bench for macc_accumulator: directed frames plus randomized traffic
// against a per-cycle arithmetic model of the dot product.
module tb_macc_accumulator;

  logic               Clk_i = 1'b0;
  logic               Rst_i;
  logic signed [15:0] Data_i;
  logic signed [15:0] Coeff_i;
  logic               StartAcc_i;
  logic               DataValid_i;
  logic signed [15:0] Result_o;
  logic               ResultValid_o;
  logic               Sat_o;

  int checks = 0;
  int errors = 0;

`ifdef MACC_ROUND_EN
  localparam longint RoundAdd = 64'sd16384;
`else
  localparam longint RoundAdd = 64'sd0;
`endif

  // Model state: running dot product, pending expectation and held output.
  longint             sum_m;
  int                 since_start;
  logic               pend_v;
  logic signed [15:0] pend_r;
  logic               pend_s;
  logic signed [15:0] last_r;
  logic               last_s;

  macc_accumulator dut (
    .Clk_i        (Clk_i),
    .Rst_i        (Rst_i),
    .Data_i       (Data_i),
    .Coeff_i      (Coeff_i),
    .StartAcc_i   (StartAcc_i),
    .DataValid_i  (DataValid_i),
    .Result_o     (Result_o),
    .ResultValid_o(ResultValid_o),
    .Sat_o        (Sat_o)
  );

  always #5 Clk_i = ~Clk_i;

  function automatic void model_out(input longint acc, output logic signed [15:0] r,
                                    output logic s);
    longint t;
    t = (acc + RoundAdd) >>> 15;
    s = 1'b0;
    if (t > 32767) begin
      t = 32767;
      s = 1'b1;
    end else if (t < -32768) begin
      t = -32768;
      s = 1'b1;
    end
    r = 16'(t);
  endfunction

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic signed [15:0] obs,
                         input logic signed [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus; called at a falling edge, returns at the next one.
  task automatic step(input logic st, input logic dv, input logic signed [15:0] d,
                      input logic signed [15:0] c);
    logic               nv;
    logic signed [15:0] nr;
    logic               ns;
    StartAcc_i  = st;
    DataValid_i = dv;
    Data_i      = d;
    Coeff_i     = c;
    nv = dv;
    nr = '0;
    ns = 1'b0;
    // DataValid closes the sum of pairs before this cycle.
    if (dv) model_out(sum_m, nr, ns);
    if (st) begin
      sum_m       = longint'(d) * longint'(c);
      since_start = 1;
    end else begin
      sum_m       = sum_m + longint'(d) * longint'(c);
      since_start = since_start + 1;
    end
    @(posedge Clk_i);
    @(negedge Clk_i);
    if (pend_v) begin
      last_r = pend_r;
      last_s = pend_s;
    end
    chk_bit("valid", ResultValid_o, pend_v);
    chk_res("result", Result_o, last_r);
    chk_bit("sat", Sat_o, last_s);
    pend_v = nv;
    pend_r = nr;
    pend_s = ns;
  endtask

  // n pairs of d*c, close with DataValid, then wait until the result is out.
  task automatic frame(input int n, input logic signed [15:0] d, input logic signed [15:0] c);
    for (int i = 0; i < n; i++) step(i == 0, 1'b0, d, c);
    step(1'b0, 1'b1, 16'sd0, 16'sd0);
    step(1'b0, 1'b0, 16'sd0, 16'sd0);
  endtask

  task automatic model_clear();
    sum_m       = 0;
    since_start = 0;
    pend_v      = 1'b0;
    pend_r      = '0;
    pend_s      = 1'b0;
    last_r      = '0;
    last_s      = 1'b0;
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear without waiting for a clock.
  task automatic do_reset();
    #2;
    Rst_i = 1'b1;
    #1;
    chk_bit("rst_valid_async", ResultValid_o, 1'b0);
    chk_res("rst_result_async", Result_o, 16'sd0);
    chk_bit("rst_sat_async", Sat_o, 1'b0);
    StartAcc_i  = 1'b0;
    DataValid_i = 1'b0;
    @(posedge Clk_i);
    @(posedge Clk_i);
    @(negedge Clk_i);
    chk_bit("rst_valid_held", ResultValid_o, 1'b0);
    Rst_i = 1'b0;
    model_clear();
  endtask

  initial begin
    logic st, dv;
    Rst_i       = 1'b1;
    StartAcc_i  = 1'b0;
    DataValid_i = 1'b0;
    Data_i      = '0;
    Coeff_i     = '0;
    model_clear();
    #1;
    chk_bit("init_valid", ResultValid_o, 1'b0);
    chk_res("init_result", Result_o, 16'sd0);
    chk_bit("init_sat", Sat_o, 1'b0);
    @(negedge Clk_i);
    Rst_i = 1'b0;

    // Basic sum.
    frame(8, 16'sd1000, 16'sd2000);
    chk_res("basic_result", Result_o, 16'sd488);
    chk_bit("basic_sat", Sat_o, 1'b0);

    // Rounding ties.
    frame(1, 16'sd16384, 16'sd1);
`ifdef MACC_ROUND_EN
    chk_res("tie_pos", Result_o, 16'sd1);
`else
    chk_res("tie_pos", Result_o, 16'sd0);
`endif
    frame(1, -16'sd16384, 16'sd1);
`ifdef MACC_ROUND_EN
    chk_res("tie_neg", Result_o, 16'sd0);
`else
    chk_res("tie_neg", Result_o, -16'sd1);
`endif

    // Saturation both ways.
    frame(8, 16'sd32767, 16'sd32767);
    chk_res("sat_pos_result", Result_o, 16'sd32767);
    chk_bit("sat_pos_flag", Sat_o, 1'b1);
    frame(8, -16'sd32768, 16'sd32767);
    chk_res("sat_neg_result", Result_o, -16'sd32768);
    chk_bit("sat_neg_flag", Sat_o, 1'b1);

    // Reset mid-accumulation with a DataValid already in flight.
    step(1'b1, 1'b0, 16'sd30000, 16'sd30000);
    step(1'b0, 1'b0, 16'sd30000, 16'sd30000);
    step(1'b0, 1'b1, 16'sd0, 16'sd0);
    do_reset();
    frame(2, 16'sd1000, 16'sd2000);
    chk_res("post_rst_result", Result_o, 16'sd122);

    // Restart after garbage.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'($urandom), 16'($urandom));
    frame(3, 16'sd1024, 16'sd64);
    chk_res("restart_result", Result_o, 16'sd6);
    chk_bit("restart_sat", Sat_o, 1'b0);

    // Overlapping close and open in the same cycle.
    for (int i = 0; i < 4; i++) step(i == 0, 1'b0, 16'sd8192, 16'sd8);
    for (int i = 0; i < 4; i++) begin
      step(i == 0, i == 0, -16'sd8192, 16'sd8);
      if (i == 1) chk_res("overlap_first", Result_o, 16'sd8);
    end
    step(1'b0, 1'b1, 16'sd0, 16'sd0);
    step(1'b0, 1'b0, 16'sd0, 16'sd0);
    chk_res("overlap_second", Result_o, -16'sd8);

    // Back-to-back DataValid.
    step(1'b1, 1'b0, 16'sd1000, 16'sd2000);
    step(1'b0, 1'b1, 16'sd1000, 16'sd2000);
    step(1'b0, 1'b1, 16'sd0, 16'sd0);
    chk_res("b2b_first", Result_o, 16'sd61);
    step(1'b0, 1'b0, 16'sd0, 16'sd0);
    chk_res("b2b_second", Result_o, 16'sd122);
    chk_bit("b2b_second_valid", ResultValid_o, 1'b1);

    // Randomized traffic; restart forced before the accumulator could outgrow its guard bits.
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(5) == 0) || (since_start >= 12);
      dv = ($urandom_range(4) == 0);
      step(st, dv, 16'($urandom), 16'($urandom));
    end
    step(1'b0, 1'b0, 16'sd0, 16'sd0);
    step(1'b0, 1'b0, 16'sd0, 16'sd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/macc_accumulator.md
# macc_accumulator

Single-multiplier accumulate datapath of the fractional (L/M) decimator, directly downstream of the decimator control block. Each cycle it multiplies the data-RAM word and the coefficient-ROM word addressed by the control block and accumulates the products. It restarts on the control block's start strobe and, on its done strobe, rounds and saturates the dot product into one output sample with a valid pulse.

## Interface
- DataWidth, 16, signed sample width on Data_i
- CoeffWidth, 16, signed coefficient width on Coeff_i
- GuardBits, 4, extra accumulator MSBs; AccWidth = DataWidth + CoeffWidth + GuardBits
- ShiftBits, 15, accumulator LSBs discarded at output; must be >= 1
- OutWidth, 16, signed result width
- Clk_i  input  1  clock, all logic on rising edge
- Rst_i  input  1  asynchronous, active-high reset
- Data_i  input  DataWidth  sample read from data RAM
- Coeff_i  input  CoeffWidth  coefficient read from coefficient ROM
- StartAcc_i  input  1  first operand pair of a dot product is on Data_i/Coeff_i this cycle
- DataValid_i  input  1  previous cycle carried the last operand pair
- Result_o  output  OutWidth  rounded, saturated output sample
- ResultValid_o  output  1  one-cycle pulse, Result_o new
- Sat_o  output  1  Result_o of this pulse was clipped; valid with ResultValid_o

## Operation
- Stage P, product: prod <= Data_i * Coeff_i (signed, DataWidth+CoeffWidth bits); startP <= StartAcc_i.
- Stage A, accumulate: if startP, acc <= sext(prod), otherwise acc <= acc + sext(prod). The accumulator runs every cycle; operands between dot products are don't-care and are flushed by the next start.
- doneA <= DataValid_i. In the cycle doneA is high, acc holds exactly the sum of pairs from the StartAcc_i cycle through the cycle before DataValid_i.
- Stage O, output: on doneA, compute shifted = (acc + R) >>> ShiftBits (arithmetic). R is defined under Configuration. Clip shifted to [-2^(OutWidth-1), 2^(OutWidth-1)-1] and register it into Result_o. Sat_o <= clipped. ResultValid_o <= 1.
- On cycles without doneA: ResultValid_o <= 0. Result_o and Sat_o hold.
- Rounding addition is done at AccWidth+1 bits, so it never wraps.
- Accumulator wrap beyond AccWidth is not detected. GuardBits sizes it for 2^GuardBits maximum-magnitude products.

## Timing
- Reset: prod, acc, startP, doneA, Result_o, ResultValid_o and Sat_o all go to 0 immediately. Reset mid-accumulation discards the partial sum, and no ResultValid_o follows for it.
- Latency: an operand pair at cycle c is in acc at c+2. ResultValid_o rises exactly 2 cycles after DataValid_i and lasts 1 cycle.
- StartAcc_i and DataValid_i in the same cycle are legal. DataValid_i closes the previous dot product with an unchanged result, and StartAcc_i opens the new one.
- Back-to-back DataValid_i on consecutive cycles gives consecutive ResultValid_o pulses.
- DataValid_i with no StartAcc_i since reset outputs the sum accumulated since reset.
- A single-pair dot product has StartAcc_i at cycle c and DataValid_i at c+1.
- There is no backpressure. The consumer must accept every ResultValid_o pulse.

## Configuration
- MACC_ROUND_EN defined: R = 2^(ShiftBits-1), giving round-half-up (toward +inf on ties).
- MACC_ROUND_EN undefined: R = 0, giving truncation toward -inf. The adder is removed.

## Structure
- Shared package macc_pkg holds:
  - the AccWidth derivation and OutWidth min/max constants
  - the saturate function, shared with the future interpolator output stage
- One sub-module, macc_round_sat: acc in, round/shift/clip, Result plus clipped flag out. It is combinational and registered by the parent.
- Ports and stage names stay aligned with the control block's StartAcc/DataValid delay chain.

## Test plan
- Use default parameters.
- Basic sum: 8 pairs of 1000 * 2000, StartAcc_i on pair 0, DataValid_i one cycle after pair 7. Expect Result_o = 488 and Sat_o = 0 exactly 2 cycles after DataValid_i.
- Rounding tie: one pair 16384 * 1. Expect Result_o = 1 with MACC_ROUND_EN and 0 without. Also -16384 * 1 gives 0 with MACC_ROUND_EN and -1 without.
- Saturation: 8 pairs of 32767 * 32767. Expect Result_o = 32767 and Sat_o = 1. Then 8 pairs of -32768 * 32767. Expect Result_o = -32768 and Sat_o = 1.
- Restart: garbage pairs before StartAcc_i, then 3 pairs of 100 * 32768/2^? Use 3 pairs of 1024 * 64. Expect Result_o = 6, and garbage is excluded.
- Overlap: DataValid_i and StartAcc_i in the same cycle, with two dot products of 4 pairs of 8192 * 8 and 4 pairs of -8192 * 8. Expect results 8 then -8 on consecutive frames.
- Reset: assert Rst_i mid-accumulation. Expect all outputs 0 at once and no ResultValid_o for that dot product. The next dot product must be correct.
